// File: rtl/pong_game_ctrl.sv
// Pong game-logic sequencer: per-frame paddle/ball update, collisions, scoring and match FSM.
// Optional build macro PONG_CPU_PLAYER_EN makes the right paddle track the ball instead of its buttons.
module pong_game_ctrl #(
   parameter int SCREEN_W       = 640,
   parameter int SCREEN_H       = 480,
   parameter int PADDLE_W       = 8,
   parameter int PADDLE_H       = 64,
   parameter int BALL_SIZE      = 8,
   parameter int LEFT_PADDLE_X  = 16,
   parameter int RIGHT_PADDLE_X = 616,
   parameter int PADDLE_SPEED   = 4,
   parameter int BALL_SPEED     = 2,
   parameter int WIN_SCORE      = 9,
   parameter int SERVE_DELAY    = 60
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       FRAME_TICK_I,
   input  logic       BTN_START_I,
   input  logic       BTN_L_UP_I,
   input  logic       BTN_L_DN_I,
   input  logic       BTN_R_UP_I,
   input  logic       BTN_R_DN_I,
   output logic [9:0] BALL_X_O,
   output logic [9:0] BALL_Y_O,
   output logic [9:0] PADDLE_L_Y_O,
   output logic [9:0] PADDLE_R_Y_O,
   output logic [3:0] SCORE_L_O,
   output logic [3:0] SCORE_R_O,
   output logic [1:0] STATE_O,
   output logic       BALL_VISIBLE_O
);

   typedef logic signed [10:0] coord_t;

   typedef enum logic [2:0] {
      SEQ_IDLE    = 3'd0,
      SEQ_PADDLE  = 3'd1,
      SEQ_BALL    = 3'd2,
      SEQ_COLLIDE = 3'd3,
      SEQ_COMMIT  = 3'd4
   } seq_t;

   typedef enum logic [1:0] {
      ATTRACT   = 2'd0,
      SERVE     = 2'd1,
      PLAY      = 2'd2,
      GAME_OVER = 2'd3
   } match_t;

   localparam int SC_W = $clog2(SERVE_DELAY);

   localparam coord_t C_ZERO  = 11'sd0;
   localparam coord_t C_PSPD  = coord_t'(PADDLE_SPEED);
   localparam coord_t C_BSPD  = coord_t'(BALL_SPEED);
   localparam coord_t C_PMAX  = coord_t'(SCREEN_H - PADDLE_H);
   localparam coord_t C_BALL  = coord_t'(BALL_SIZE);
   localparam coord_t C_PH    = coord_t'(PADDLE_H);
   localparam coord_t C_PW    = coord_t'(PADDLE_W);
   localparam coord_t C_LPX   = coord_t'(LEFT_PADDLE_X);
   localparam coord_t C_RPX   = coord_t'(RIGHT_PADDLE_X);
   localparam coord_t C_BMAXX = coord_t'(SCREEN_W - BALL_SIZE);
   localparam coord_t C_BMAXY = coord_t'(SCREEN_H - BALL_SIZE);

   localparam logic [9:0] CENTRE_X   = 10'((SCREEN_W - BALL_SIZE) / 2);
   localparam logic [9:0] CENTRE_Y   = 10'((SCREEN_H - BALL_SIZE) / 2);
   localparam logic [9:0] PADDLE_Y0  = 10'((SCREEN_H - PADDLE_H) / 2);
   localparam logic [9:0] L_BOUNCE_X = 10'(LEFT_PADDLE_X + PADDLE_W);
   localparam logic [9:0] R_BOUNCE_X = 10'(RIGHT_PADDLE_X - BALL_SIZE);
   localparam logic [9:0] BOTTOM_Y   = 10'(SCREEN_H - BALL_SIZE);
   localparam logic [3:0] C_WIN      = 4'(WIN_SCORE);
   localparam logic [SC_W-1:0] SERVE_LAST = SC_W'(SERVE_DELAY - 1);

   seq_t            seq;
   match_t          match;
   logic [9:0]      ball_x, ball_y, pad_l, pad_r;
   logic [3:0]      score_l, score_r;
   logic            vx_neg, vy_neg, visible;
   logic [SC_W-1:0] serve_cnt;

   logic [9:0]      pl_nxt, pr_nxt;
   coord_t          nx, ny;
   logic [9:0]      res_x, res_y;
   logic            res_vx_neg, res_vy_neg, point_l, point_r;

   logic [9:0]      hit_x, hit_y;
   logic            hit_vx_neg, hit_vy_neg, hit_l, hit_r, score_l_pt, score_r_pt;
   coord_t          pl_s, pr_s;

   function automatic logic [9:0] paddle_move(input logic [9:0] y, input logic up, input logic dn);
      coord_t t;
      t = $signed({1'b0, y});
      if (up && !dn) t = t - C_PSPD;
      else if (dn && !up) t = t + C_PSPD;
      else t = t;
      if (t < C_ZERO) t = C_ZERO;
      else if (t > C_PMAX) t = C_PMAX;
      else t = t;
      return t[9:0];
   endfunction

   function automatic logic [3:0] sat_inc(input logic [3:0] s);
      return (s >= C_WIN) ? C_WIN : s + 4'd1;
   endfunction

`ifdef PONG_CPU_PLAYER_EN
   localparam coord_t C_HALF_PH   = coord_t'(PADDLE_H / 2);
   localparam coord_t C_HALF_BALL = coord_t'(BALL_SIZE / 2);
   localparam coord_t C_DEAD      = 11'sd4;

   // Dead band around the ball centre keeps the CPU paddle from jittering.
   function automatic logic [9:0] cpu_track(input logic [9:0] py, input logic [9:0] by);
      coord_t pc, bc;
      pc = $signed({1'b0, py}) + C_HALF_PH;
      bc = $signed({1'b0, by}) + C_HALF_BALL;
      if (pc < bc - C_DEAD) return paddle_move(py, 1'b0, 1'b1);
      else if (pc > bc + C_DEAD) return paddle_move(py, 1'b1, 1'b0);
      else return py;
   endfunction

   logic unused_r_btn;
   assign unused_r_btn = BTN_R_UP_I ^ BTN_R_DN_I;
`endif

   // Collision resolution from the tentative ball position and updated paddles.
   always_comb begin
      pl_s       = $signed({1'b0, pl_nxt});
      pr_s       = $signed({1'b0, pr_nxt});
      hit_y      = ny[9:0];
      hit_vy_neg = vy_neg;
      if (ny <= C_ZERO) begin
         hit_y      = 10'd0;
         hit_vy_neg = 1'b0;
      end else if (ny >= C_BMAXY) begin
         hit_y      = BOTTOM_Y;
         hit_vy_neg = 1'b1;
      end else begin
         hit_y      = ny[9:0];
         hit_vy_neg = vy_neg;
      end

      hit_l = vx_neg && (nx <= C_LPX + C_PW) && (nx + C_BALL > C_LPX)
              && (ny + C_BALL > pl_s) && (ny < pl_s + C_PH);
      hit_r = !vx_neg && (nx + C_BALL >= C_RPX) && (nx < C_RPX + C_PW)
              && (ny + C_BALL > pr_s) && (ny < pr_s + C_PH);

      hit_x      = nx[9:0];
      hit_vx_neg = vx_neg;
      score_l_pt = 1'b0;
      score_r_pt = 1'b0;
      if (hit_l) begin
         hit_x      = L_BOUNCE_X;
         hit_vx_neg = 1'b0;
      end else if (hit_r) begin
         hit_x      = R_BOUNCE_X;
         hit_vx_neg = 1'b1;
      end else if (nx <= C_ZERO) begin
         score_r_pt = 1'b1;
      end else if (nx >= C_BMAXX) begin
         score_l_pt = 1'b1;
      end else begin
         hit_x = nx[9:0];
      end
   end

   // Frame update sequencer and match state machine; all outputs load at COMMIT.
   always_ff @(posedge CLK) begin
      if (RST) begin
         seq        <= SEQ_IDLE;
         match      <= ATTRACT;
         ball_x     <= CENTRE_X;
         ball_y     <= CENTRE_Y;
         pad_l      <= PADDLE_Y0;
         pad_r      <= PADDLE_Y0;
         score_l    <= 4'd0;
         score_r    <= 4'd0;
         vx_neg     <= 1'b0;
         vy_neg     <= 1'b0;
         visible    <= 1'b0;
         serve_cnt  <= '0;
         pl_nxt     <= PADDLE_Y0;
         pr_nxt     <= PADDLE_Y0;
         nx         <= C_ZERO;
         ny         <= C_ZERO;
         res_x      <= CENTRE_X;
         res_y      <= CENTRE_Y;
         res_vx_neg <= 1'b0;
         res_vy_neg <= 1'b0;
         point_l    <= 1'b0;
         point_r    <= 1'b0;
      end else begin
         case (seq)
            SEQ_IDLE: begin
               if (FRAME_TICK_I) seq <= SEQ_PADDLE;
               else seq <= SEQ_IDLE;
            end
            SEQ_PADDLE: begin
               if (match == SERVE || match == PLAY) begin
                  pl_nxt <= paddle_move(pad_l, BTN_L_UP_I, BTN_L_DN_I);
`ifdef PONG_CPU_PLAYER_EN
                  pr_nxt <= cpu_track(pad_r, ball_y);
`else
                  pr_nxt <= paddle_move(pad_r, BTN_R_UP_I, BTN_R_DN_I);
`endif
               end else begin
                  pl_nxt <= pad_l;
                  pr_nxt <= pad_r;
               end
               seq <= SEQ_BALL;
            end
            SEQ_BALL: begin
               nx  <= vx_neg ? $signed({1'b0, ball_x}) - C_BSPD : $signed({1'b0, ball_x}) + C_BSPD;
               ny  <= vy_neg ? $signed({1'b0, ball_y}) - C_BSPD : $signed({1'b0, ball_y}) + C_BSPD;
               seq <= SEQ_COLLIDE;
            end
            SEQ_COLLIDE: begin
               res_x      <= hit_x;
               res_y      <= hit_y;
               res_vx_neg <= hit_vx_neg;
               res_vy_neg <= hit_vy_neg;
               point_l    <= score_l_pt;
               point_r    <= score_r_pt;
               seq        <= SEQ_COMMIT;
            end
            SEQ_COMMIT: begin
               pad_l <= pl_nxt;
               pad_r <= pr_nxt;
               case (match)
                  ATTRACT, GAME_OVER: begin
                     if (BTN_START_I) begin
                        match     <= SERVE;
                        visible   <= 1'b1;
                        score_l   <= 4'd0;
                        score_r   <= 4'd0;
                        ball_x    <= CENTRE_X;
                        ball_y    <= CENTRE_Y;
                        vx_neg    <= 1'b0;
                        vy_neg    <= 1'b0;
                        serve_cnt <= '0;
                     end else begin
                        visible <= 1'b0;
                     end
                  end
                  SERVE: begin
                     ball_x  <= CENTRE_X;
                     ball_y  <= CENTRE_Y;
                     visible <= 1'b1;
                     if (serve_cnt == SERVE_LAST) begin
                        serve_cnt <= '0;
                        match     <= PLAY;
                     end else begin
                        serve_cnt <= serve_cnt + SC_W'(1);
                     end
                  end
                  PLAY: begin
                     if (point_l || point_r) begin
                        // Ball stays where it was on the winning point; otherwise re-serve at the loser.
                        if (point_l) score_l <= sat_inc(score_l);
                        else score_r <= sat_inc(score_r);
                        if ((point_l && sat_inc(score_l) == C_WIN) ||
                            (point_r && sat_inc(score_r) == C_WIN)) begin
                           match   <= GAME_OVER;
                           visible <= 1'b0;
                        end else begin
                           match   <= SERVE;
                           visible <= 1'b1;
                           ball_x  <= CENTRE_X;
                           ball_y  <= CENTRE_Y;
                           vx_neg  <= point_r;
                           vy_neg  <= 1'b0;
                        end
                     end else begin
                        ball_x  <= res_x;
                        ball_y  <= res_y;
                        vx_neg  <= res_vx_neg;
                        vy_neg  <= res_vy_neg;
                        visible <= 1'b1;
                     end
                  end
                  default: begin
                     match   <= ATTRACT;
                     visible <= 1'b0;
                  end
               endcase
               seq <= SEQ_IDLE;
            end
            default: seq <= SEQ_IDLE;
         endcase
      end
   end

   assign BALL_X_O       = ball_x;
   assign BALL_Y_O       = ball_y;
   assign PADDLE_L_Y_O   = pad_l;
   assign PADDLE_R_Y_O   = pad_r;
   assign SCORE_L_O      = score_l;
   assign SCORE_R_O      = score_r;
   assign STATE_O        = match;
   assign BALL_VISIBLE_O = visible;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl: a frame-level reference model pushes expected outputs,
// a monitor checks them at each commit and checks output stability on every other cycle.
module tb_pong_game_ctrl;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       FRAME_TICK_I = 1'b0;
   logic       BTN_START_I = 1'b0;
   logic       BTN_L_UP_I = 1'b0, BTN_L_DN_I = 1'b0, BTN_R_UP_I = 1'b0, BTN_R_DN_I = 1'b0;
   logic [9:0] BALL_X_O, BALL_Y_O, PADDLE_L_Y_O, PADDLE_R_Y_O;
   logic [3:0] SCORE_L_O, SCORE_R_O;
   logic [1:0] STATE_O;
   logic       BALL_VISIBLE_O;

   pong_game_ctrl dut (
      .CLK(CLK), .RST(RST), .FRAME_TICK_I(FRAME_TICK_I), .BTN_START_I(BTN_START_I),
      .BTN_L_UP_I(BTN_L_UP_I), .BTN_L_DN_I(BTN_L_DN_I),
      .BTN_R_UP_I(BTN_R_UP_I), .BTN_R_DN_I(BTN_R_DN_I),
      .BALL_X_O(BALL_X_O), .BALL_Y_O(BALL_Y_O),
      .PADDLE_L_Y_O(PADDLE_L_Y_O), .PADDLE_R_Y_O(PADDLE_R_Y_O),
      .SCORE_L_O(SCORE_L_O), .SCORE_R_O(SCORE_R_O),
      .STATE_O(STATE_O), .BALL_VISIBLE_O(BALL_VISIBLE_O)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int bx, by, pl, pr, sl, sr, st, vis, due;
   } exp_t;

   exp_t q[$];
   exp_t cur;
   int   checks = 0, failures = 0, prints = 0;
   int   cyc = 0, last_k = -100;
   bit   mon_en = 1'b0;

   // Game model in plain integer arithmetic
   int m_bx, m_by, m_pl, m_pr, m_sl, m_sr, m_st, m_vx, m_vy, m_scnt;

   always @(posedge CLK) cyc <= cyc + 1;

   function automatic int clampi(input int v, input int lo, input int hi);
      return (v < lo) ? lo : ((v > hi) ? hi : v);
   endfunction

   task automatic model_reset();
      m_bx = 316; m_by = 236; m_pl = 208; m_pr = 208;
      m_sl = 0; m_sr = 0; m_st = 0; m_vx = 1; m_vy = 1; m_scnt = 0;
   endtask

   function automatic exp_t snapshot(input int due);
      exp_t e;
      e.bx = m_bx; e.by = m_by; e.pl = m_pl; e.pr = m_pr;
      e.sl = m_sl; e.sr = m_sr; e.st = m_st;
      e.vis = (m_st == 1 || m_st == 2) ? 1 : 0;
      e.due = due;
      return e;
   endfunction

   task automatic serve_new();
      m_st = 1; m_sl = 0; m_sr = 0; m_vx = 1; m_vy = 1;
      m_bx = 316; m_by = 236; m_scnt = 0;
   endtask

   task automatic model_frame(input bit lu, input bit ld, input bit ru, input bit rd, input bit start);
      int npl, npr, nx, ny, cx, cy, cvx, cvy, pc, bc;
      bit hl, hr, ptl, ptr;
      npl = m_pl; npr = m_pr;
      if (m_st == 1 || m_st == 2) begin
         npl = clampi(m_pl + 4 * (int'(ld) - int'(lu)), 0, 416);
`ifdef PONG_CPU_PLAYER_EN
         pc = m_pr + 32; bc = m_by + 4;
         if (pc < bc - 4) npr = clampi(m_pr + 4, 0, 416);
         else if (pc > bc + 4) npr = clampi(m_pr - 4, 0, 416);
`else
         pc = 0; bc = 0;
         npr = clampi(m_pr + 4 * (int'(rd) - int'(ru)), 0, 416);
`endif
      end
      nx = m_bx + 2 * m_vx;
      ny = m_by + 2 * m_vy;
      cvy = m_vy; cy = ny;
      if (ny <= 0) begin cy = 0; cvy = 1; end
      else if (ny >= 472) begin cy = 472; cvy = -1; end
      hl = (m_vx < 0) && nx <= 24 && nx + 8 > 16 && ny + 8 > npl && ny < npl + 64;
      hr = (m_vx > 0) && nx + 8 >= 616 && nx < 624 && ny + 8 > npr && ny < npr + 64;
      cx = nx; cvx = m_vx; ptl = 0; ptr = 0;
      if (hl) begin cx = 24; cvx = 1; end
      else if (hr) begin cx = 608; cvx = -1; end
      else if (nx <= 0) ptr = 1;
      else if (nx >= 632) ptl = 1;
      case (m_st)
         0, 3: if (start) serve_new();
         1: begin
            m_bx = 316; m_by = 236;
            if (m_scnt == 59) begin m_scnt = 0; m_st = 2; end
            else m_scnt++;
         end
         default: begin
            if (ptl || ptr) begin
               if (ptl) m_sl = (m_sl + 1 > 9) ? 9 : m_sl + 1;
               else m_sr = (m_sr + 1 > 9) ? 9 : m_sr + 1;
               if (m_sl == 9 || m_sr == 9) m_st = 3;
               else begin
                  m_st = 1; m_bx = 316; m_by = 236; m_vy = 1;
                  m_vx = ptr ? -1 : 1;
               end
            end else begin
               m_bx = cx; m_by = cy; m_vx = cvx; m_vy = cvy;
            end
         end
      endcase
      m_pl = npl; m_pr = npr;
   endtask

   task automatic check_out(input exp_t e, input string tag);
      checks++;
      if (int'(BALL_X_O) != e.bx || int'(BALL_Y_O) != e.by || int'(PADDLE_L_Y_O) != e.pl ||
          int'(PADDLE_R_Y_O) != e.pr || int'(SCORE_L_O) != e.sl || int'(SCORE_R_O) != e.sr ||
          int'(STATE_O) != e.st || int'(BALL_VISIBLE_O) != e.vis) begin
         failures++;
         if (prints < 30) begin
            prints++;
            $display("FAIL %s cyc=%0d got ball=(%0d,%0d) pad=(%0d,%0d) score=(%0d,%0d) st=%0d vis=%0d want ball=(%0d,%0d) pad=(%0d,%0d) score=(%0d,%0d) st=%0d vis=%0d",
                     tag, cyc, BALL_X_O, BALL_Y_O, PADDLE_L_Y_O, PADDLE_R_Y_O, SCORE_L_O, SCORE_R_O,
                     STATE_O, BALL_VISIBLE_O, e.bx, e.by, e.pl, e.pr, e.sl, e.sr, e.st, e.vis);
         end
      end
   endtask

   // Monitor: pop at the due commit cycle, otherwise outputs must hold the last expectation.
   always @(negedge CLK) begin
      if (mon_en) begin
         if (q.size() > 0 && q[0].due == cyc) begin
            cur = q.pop_front();
            check_out(cur, "commit");
         end else if (q.size() > 0 && q[0].due < cyc) begin
            failures++;
            $display("FAIL missed_commit cyc=%0d due=%0d", cyc, q[0].due);
            cur = q.pop_front();
         end else begin
            check_out(cur, "stable");
         end
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic tick_frame(input bit lu, input bit ld, input bit ru, input bit rd,
                             input bit start, input int extra_off);
      int k;
      while (cyc < last_k + 5) step();
      BTN_L_UP_I = lu; BTN_L_DN_I = ld; BTN_R_UP_I = ru; BTN_R_DN_I = rd;
      BTN_START_I = start;
      FRAME_TICK_I = 1'b1;
      k = cyc;
      last_k = k;
      model_frame(lu, ld, ru, rd, start);
      q.push_back(snapshot(k + 5));
      step();
      FRAME_TICK_I = 1'b0;
      if (extra_off >= 2) begin
         // Tick landing while the update is still in flight must be ignored.
         while (cyc < k + extra_off) step();
         FRAME_TICK_I = 1'b1;
         step();
         FRAME_TICK_I = 1'b0;
      end
   endtask

   task automatic reset_mid_update();
      int k;
      while (cyc < last_k + 5) step();
      FRAME_TICK_I = 1'b1;
      k = cyc;
      step();
      FRAME_TICK_I = 1'b0;
      while (cyc < k + 3) step();
      RST = 1'b1;
      model_reset();
      q.push_back(snapshot(k + 4));
      step();
      RST = 1'b0;
      last_k = cyc - 5;
   endtask

   initial begin
      bit lu, ld, ru, rd, st;
      int extra, guard;
      model_reset();
      repeat (3) step();
      cur = snapshot(0);
      mon_en = 1'b1;
      RST = 1'b0;
      step();

      repeat (3) tick_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      tick_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
      repeat (60) tick_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      tick_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
      repeat (60) tick_frame(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
      repeat (10) tick_frame(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3);
      reset_mid_update();

      ru = 1'b0; rd = 1'b0;
      for (int f = 0; f < 6000; f++) begin
         repeat ($urandom_range(0, 3)) step();
         if ($urandom_range(0, 3) != 0) begin
            // Left paddle mostly steers away from the ball so points get scored.
            lu = (m_by + 4 >= m_pl + 32);
            ld = !lu;
         end else begin
            lu = 1'($urandom_range(0, 1));
            ld = 1'($urandom_range(0, 1));
         end
         if ($urandom_range(0, 7) == 0) begin
            ru = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
         end
         st = ($urandom_range(0, 7) == 0);
         extra = ($urandom_range(0, 9) == 0) ? $urandom_range(2, 4) : 0;
         if (f == 3000) reset_mid_update();
         tick_frame(lu, ld, ru, rd, st, extra);
      end

      guard = 0;
      while (q.size() > 0 && guard < 50) begin
         step();
         guard++;
      end
      step();
      if (q.size() > 0) begin
         failures++;
         $display("FAIL drain pending=%0d want 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      failures++;
      $display("FAIL timeout cyc=%0d", cyc);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Game-logic sequencer for the Nexys4 pong top level. On each frame tick it updates the paddle positions from the buttons, moves the ball and resolves wall and paddle collisions. It also keeps score and runs the match state machine. Its outputs are registered object coordinates and scores, which the VGA renderer samples during active video.

Parameters:
SCREEN_W, 640, visible width in pixels
SCREEN_H, 480, visible height in pixels
PADDLE_W, 8, paddle width
PADDLE_H, 64, paddle height
BALL_SIZE, 8, ball edge length (square)
LEFT_PADDLE_X, 16, left paddle x (left edge)
RIGHT_PADDLE_X, 616, right paddle x (left edge)
PADDLE_SPEED, 4, paddle pixels per frame
BALL_SPEED, 2, ball pixels per frame on each axis
WIN_SCORE, 9, points needed to win (must be ≤15)
SERVE_DELAY, 60, frames spent in SERVE before the ball moves

Ports:
CLK  in  1  system clock
RST  in  1  synchronous, active-high reset
FRAME_TICK_I  in  1  one-cycle pulse, once per frame at vblank start
BTN_START_I  in  1  start/restart, debounced, level
BTN_L_UP_I  in  1  left paddle up, debounced
BTN_L_DN_I  in  1  left paddle down, debounced
BTN_R_UP_I  in  1  right paddle up, debounced
BTN_R_DN_I  in  1  right paddle down, debounced
BALL_X_O  out  10  ball left edge
BALL_Y_O  out  10  ball top edge
PADDLE_L_Y_O  out  10  left paddle top edge
PADDLE_R_Y_O  out  10  right paddle top edge
SCORE_L_O  out  4  left player score
SCORE_R_O  out  4  right player score
STATE_O  out  2  match state: 0 ATTRACT, 1 SERVE, 2 PLAY, 3 GAME_OVER
BALL_VISIBLE_O  out  1  high in SERVE and PLAY only

Behaviour:
- One clock, CLK. RST is synchronous and active-high; it overrides everything, including an update in flight.
- Reset values: BALL_X_O=316, BALL_Y_O=236, both paddle Y outputs=208, both scores=0, STATE_O=0, BALL_VISIBLE_O=0, ball direction vx=+ vy=+, serve counter=0.
- Update sequencer: IDLE -> PADDLE -> BALL -> COLLIDE -> COMMIT -> IDLE, one cycle per state.
  - Leaves IDLE only on FRAME_TICK_I.
  - A tick that arrives in a non-IDLE state is ignored.
  - All outputs change together at COMMIT, 4 cycles after the tick. They stay stable at all other times.
- PADDLE step:
  - Applied only in SERVE and PLAY.
  - UP alone: y -= PADDLE_SPEED. DN alone: y += PADDLE_SPEED. Both pressed or neither: no move.
  - Clamp y to [0, SCREEN_H-PADDLE_H].
- BALL step:
  - Applied in PLAY only.
  - Next positions are computed in 11-bit signed: nx = x ± BALL_SPEED, ny = y ± BALL_SPEED.
- COLLIDE step, using nx/ny and the paddle positions from the PADDLE step:
  - Top wall: ny ≤ 0 -> y=0, vy=+.
  - Bottom wall: ny ≥ SCREEN_H-BALL_SIZE -> clamp to that value, vy=-.
  - Left paddle: vx=-, nx ≤ LEFT_PADDLE_X+PADDLE_W, nx+BALL_SIZE > LEFT_PADDLE_X, and vertical overlap (ny+BALL_SIZE > py and ny < py+PADDLE_H) -> x = LEFT_PADDLE_X+PADDLE_W, vx=+.
  - Right paddle: mirrored -> x = RIGHT_PADDLE_X-BALL_SIZE, vx=-.
  - A wall hit and a paddle hit in the same frame are both applied.
  - Miss on the left (nx ≤ 0): right player scores. Miss on the right (nx ≥ SCREEN_W-BALL_SIZE): left player scores. A paddle hit takes priority over a miss.
- Match state machine, evaluated at COMMIT:
  - ATTRACT: BTN_START_I -> SERVE; scores cleared; serve direction vx=+.
  - SERVE: ball held at centre (316,236). The serve counter increments once per frame; at SERVE_DELAY-1 it clears and the state goes to PLAY.
  - PLAY, on a point: the score increments. If the new score = WIN_SCORE -> GAME_OVER. Otherwise -> SERVE, with the ball recentred, vx aimed at the player who conceded, and vy=+.
  - GAME_OVER: scores and ball frozen. BTN_START_I -> SERVE with scores cleared.
- Scores saturate at WIN_SCORE and never wrap.

Optional Feature:
PONG_CPU_PLAYER_EN
- Defined: BTN_R_UP_I and BTN_R_DN_I are ignored. The right paddle tracks the ball in the PADDLE step:
  - If the paddle centre < ball centre - 4: move down PADDLE_SPEED.
  - If the paddle centre > ball centre + 4: move up PADDLE_SPEED.
  - Otherwise hold. The same clamps apply.
- Undefined: the right paddle is driven by its buttons. The tracking logic is not synthesised.

Test Plan:
- Reset, then 3 ticks with no start -> STATE_O=0, BALL_VISIBLE_O=0, ball (316,236), paddles 208, scores 0,0.
- Start, then 60 ticks -> STATE_O changes 1->2 at the 60th tick's COMMIT (tick+4 cycles). The next tick gives ball (318,238).
- In PLAY, hold BTN_L_UP_I for 60 ticks -> PADDLE_L_Y_O falls 208, 204, … and clamps at 0. With both L buttons held, it does not move.
- Ball at (26,100) with vx=- and left paddle y=80 -> next COMMIT gives x=24, vx=+ (the ball then moves right). With paddle y=300, the ball continues toward the left edge; at x ≤ 0 SCORE_R_O increments and STATE_O=1 with the ball recentred.
- Ball at y=2 with vy=- -> y=0, then vy=+. A tick pulsed 2 cycles after a previous tick is ignored (only one update occurs). Asserting RST during COLLIDE restores all reset values on the next edge.
- Score reaches 9 for the left player -> STATE_O=3 and outputs frozen over 10 ticks. BTN_START_I -> STATE_O=1 and scores 0,0. With PONG_CPU_PLAYER_EN defined, the right paddle converges on the ball's y while the R buttons are ignored.
